// File: rtl/io_bus_arbiter.sv
// Round-robin arbiter sharing the 16-bit peripheral IO bus between two masters,
// with a bus timeout that returns ERR_DATA and records the first failing address.
module io_bus_arbiter #(
  parameter int          TIMEOUT  = 255,
  parameter logic [15:0] ERR_DATA = 16'hDEAD
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic        m0_bus_enable,
  input  logic        m0_rw,
  input  logic [15:0] m0_address,
  input  logic [1:0]  m0_byte_enable,
  input  logic [15:0] m0_write_data,
  output logic [15:0] m0_read_data,
  output logic        m0_acknowledge,
  input  logic        m1_bus_enable,
  input  logic        m1_rw,
  input  logic [15:0] m1_address,
  input  logic [1:0]  m1_byte_enable,
  input  logic [15:0] m1_write_data,
  output logic [15:0] m1_read_data,
  output logic        m1_acknowledge,
  output logic        s_bus_enable,
  output logic        s_rw,
  output logic [15:0] s_address,
  output logic [1:0]  s_byte_enable,
  output logic [15:0] s_write_data,
  input  logic [15:0] s_read_data,
  input  logic        s_acknowledge,
  output logic        grant,
  output logic        busy,
  output logic        err_flag,
  output logic [15:0] err_addr,
  input  logic        err_clear
);

  typedef enum logic [1:0] {IDLE, GRANT, DONE} state_t;

  state_t      state_q, state_d;
  logic        ptr_q, ptr_d;
  logic        grant_q, grant_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        s_en_q, s_en_d;
  logic        s_rw_q, s_rw_d;
  logic [15:0] s_addr_q, s_addr_d;
  logic [1:0]  s_be_q, s_be_d;
  logic [15:0] s_wd_q, s_wd_d;
  logic [15:0] rd0_q, rd0_d;
  logic [15:0] rd1_q, rd1_d;
  logic        err_q, err_d;
  logic [15:0] eaddr_q, eaddr_d;

  logic winner;
  logic tmo;

  // With both requesting the pointer decides; otherwise the lone requester wins.
  assign winner = (m0_bus_enable & m1_bus_enable) ? ptr_q : m1_bus_enable;
  assign tmo    = (cnt_q == 8'(TIMEOUT - 1));

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    grant_d  = grant_q;
    cnt_d    = cnt_q;
    s_en_d   = s_en_q;
    s_rw_d   = s_rw_q;
    s_addr_d = s_addr_q;
    s_be_d   = s_be_q;
    s_wd_d   = s_wd_q;
    rd0_d    = rd0_q;
    rd1_d    = rd1_q;
    err_d    = err_q;
    eaddr_d  = eaddr_q;
    unique case (state_q)
      IDLE: begin
        if (m0_bus_enable | m1_bus_enable) begin
          grant_d  = winner;
          ptr_d    = ~winner;
          cnt_d    = 8'd0;
          s_en_d   = 1'b1;
          s_rw_d   = winner ? m1_rw          : m0_rw;
          s_addr_d = winner ? m1_address     : m0_address;
          s_be_d   = winner ? m1_byte_enable : m0_byte_enable;
          s_wd_d   = winner ? m1_write_data  : m0_write_data;
          state_d  = GRANT;
        end
      end
      GRANT: begin
        if (s_acknowledge) begin
          s_en_d  = 1'b0;
          state_d = DONE;
          if (s_rw_q) begin
            if (grant_q) rd1_d = s_read_data;
            else         rd0_d = s_read_data;
          end
        end else if (tmo) begin
          s_en_d  = 1'b0;
          state_d = DONE;
          if (s_rw_q) begin
            if (grant_q) rd1_d = ERR_DATA;
            else         rd0_d = ERR_DATA;
          end
          if (!err_q) eaddr_d = s_addr_q;
          err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A clear wins over an error raised in the same cycle.
    if (err_clear) begin
      err_d   = 1'b0;
      eaddr_d = 16'd0;
    end
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_q  <= IDLE;
      ptr_q    <= 1'b0;
      grant_q  <= 1'b0;
      cnt_q    <= 8'd0;
      s_en_q   <= 1'b0;
      s_rw_q   <= 1'b0;
      s_addr_q <= 16'd0;
      s_be_q   <= 2'd0;
      s_wd_q   <= 16'd0;
      rd0_q    <= 16'd0;
      rd1_q    <= 16'd0;
      err_q    <= 1'b0;
      eaddr_q  <= 16'd0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      cnt_q    <= cnt_d;
      s_en_q   <= s_en_d;
      s_rw_q   <= s_rw_d;
      s_addr_q <= s_addr_d;
      s_be_q   <= s_be_d;
      s_wd_q   <= s_wd_d;
      rd0_q    <= rd0_d;
      rd1_q    <= rd1_d;
      err_q    <= err_d;
      eaddr_q  <= eaddr_d;
    end
  end

  assign m0_read_data   = rd0_q;
  assign m1_read_data   = rd1_q;
  assign m0_acknowledge = (state_q == DONE) & ~grant_q;
  assign m1_acknowledge = (state_q == DONE) &  grant_q;
  assign s_bus_enable   = s_en_q;
  assign s_rw           = s_rw_q;
  assign s_address      = s_addr_q;
  assign s_byte_enable  = s_be_q;
  assign s_write_data   = s_wd_q;
  assign grant          = grant_q;
  assign busy           = (state_q != IDLE);
  assign err_flag       = err_q;
  assign err_addr       = eaddr_q;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Scoreboard bench for io_bus_arbiter: directed transfers push expected
// acknowledges; a monitor pops and compares them as the DUT acknowledges.
module tb_io_bus_arbiter;

  localparam int TMO = 8;

  logic        clk_clk = 1'b0;
  logic        reset_reset;
  logic        m0_bus_enable, m0_rw;
  logic [15:0] m0_address, m0_write_data, m0_read_data;
  logic [1:0]  m0_byte_enable;
  logic        m0_acknowledge;
  logic        m1_bus_enable, m1_rw;
  logic [15:0] m1_address, m1_write_data, m1_read_data;
  logic [1:0]  m1_byte_enable;
  logic        m1_acknowledge;
  logic        s_bus_enable, s_rw;
  logic [15:0] s_address, s_write_data;
  logic [1:0]  s_byte_enable;
  logic [15:0] s_read_data;
  logic        s_acknowledge;
  logic        grant, busy, err_flag;
  logic [15:0] err_addr;
  logic        err_clear;

  logic        auto_ack;
  logic        s_ack_drv;

  assign s_acknowledge = auto_ack ? s_bus_enable : s_ack_drv;

  io_bus_arbiter #(.TIMEOUT(TMO), .ERR_DATA(16'hDEAD)) dut (
    .clk_clk(clk_clk), .reset_reset(reset_reset),
    .m0_bus_enable(m0_bus_enable), .m0_rw(m0_rw),
    .m0_address(m0_address), .m0_byte_enable(m0_byte_enable),
    .m0_write_data(m0_write_data), .m0_read_data(m0_read_data),
    .m0_acknowledge(m0_acknowledge),
    .m1_bus_enable(m1_bus_enable), .m1_rw(m1_rw),
    .m1_address(m1_address), .m1_byte_enable(m1_byte_enable),
    .m1_write_data(m1_write_data), .m1_read_data(m1_read_data),
    .m1_acknowledge(m1_acknowledge),
    .s_bus_enable(s_bus_enable), .s_rw(s_rw),
    .s_address(s_address), .s_byte_enable(s_byte_enable),
    .s_write_data(s_write_data), .s_read_data(s_read_data),
    .s_acknowledge(s_acknowledge),
    .grant(grant), .busy(busy), .err_flag(err_flag),
    .err_addr(err_addr), .err_clear(err_clear)
  );

  always #5 clk_clk = ~clk_clk;

  typedef struct {
    int          m;
    logic [15:0] d;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] model[2];
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input int m, input logic en, input logic rw,
                         input logic [15:0] a, input logic [1:0] be,
                         input logic [15:0] wd);
    if (m == 0) begin
      m0_bus_enable = en; m0_rw = rw; m0_address = a;
      m0_byte_enable = be; m0_write_data = wd;
    end else begin
      m1_bus_enable = en; m1_rw = rw; m1_address = a;
      m1_byte_enable = be; m1_write_data = wd;
    end
  endtask

  // Monitor: every acknowledge must match the oldest expected transfer.
  exp_t e;
  logic prev_ack = 1'b0;
  always @(negedge clk_clk) begin
    if (!reset_reset) begin
      if (prev_ack)
        chk("ack_width", {30'd0, m1_acknowledge, m0_acknowledge}, 32'd0);
      else if (m0_acknowledge || m1_acknowledge) begin
        if (sb.size() == 0)
          chk("unexpected_ack", {30'd0, m1_acknowledge, m0_acknowledge}, 0);
        else begin
          e = sb.pop_front();
          chk("ack_master", {30'd0, m1_acknowledge, m0_acknowledge},
              (e.m == 1) ? 32'd2 : 32'd1);
          chk("read_data", (e.m == 1) ? m1_read_data : m0_read_data, e.d);
        end
      end
      prev_ack = m0_acknowledge | m1_acknowledge;
    end else begin
      prev_ack = 1'b0;
    end
  end

  // dly >= 0: ack raised after dly GRANT cycles without ack; dly < 0: no ack.
  task automatic xfer(input int m, input logic rw, input logic [15:0] a,
                      input logic [1:0] be, input logic [15:0] wd,
                      input int dly, input logic [15:0] rd,
                      output int lat, output int en_cyc);
    exp_t x;
    int   n;
    bit   seen;
    if (rw) model[m] = (dly < 0) ? 16'hDEAD : rd;
    x.m = m; x.d = model[m];
    sb.push_back(x);
    lat = 0; en_cyc = 0;
    set_req(m, 1'b1, rw, a, be, wd);
    n = 0; seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk_clk); n++;
      if (s_bus_enable) seen = 1;
    end
    if (!seen) begin
      chk("grant_timeout", 0, 1);
      set_req(m, 1'b0, rw, a, be, wd);
      void'(sb.pop_back());
      return;
    end
    chk("s_rw", {31'd0, s_rw}, {31'd0, rw});
    chk("s_address", {16'd0, s_address}, {16'd0, a});
    chk("s_byte_enable", {30'd0, s_byte_enable}, {30'd0, be});
    chk("s_write_data", {16'd0, s_write_data}, {16'd0, wd});
    chk("grant_idx", {31'd0, grant}, m);
    en_cyc = 1;
    if (dly >= 0) begin
      for (int i = 0; i < dly; i++) begin
        @(negedge clk_clk); n++;
      end
      s_ack_drv = 1'b1; s_read_data = rd;
      @(negedge clk_clk); n++;
      s_ack_drv = 1'b0;
    end else begin
      for (int i = 0; i < 400; i++) begin
        @(negedge clk_clk); n++;
        if (!s_bus_enable) break;
        en_cyc++;
      end
    end
    chk("done_ack", {31'd0, (m == 1) ? m1_acknowledge : m0_acknowledge}, 1);
    chk("done_s_en", {31'd0, s_bus_enable}, 0);
    chk("done_busy", {31'd0, busy}, 1);
    lat = n;
    set_req(m, 1'b0, 1'b0, 16'd0, 2'd0, 16'd0);
    @(negedge clk_clk);
  endtask

  int lat, en_cyc;
  int who[4];
  int tk[4];
  int na;

  initial begin
    reset_reset = 1'b1; err_clear = 1'b0;
    auto_ack = 1'b0; s_ack_drv = 1'b0; s_read_data = 16'd0;
    set_req(0, 1'b0, 1'b0, 16'd0, 2'd0, 16'd0);
    set_req(1, 1'b0, 1'b0, 16'd0, 2'd0, 16'd0);
    model[0] = 16'd0; model[1] = 16'd0;
    repeat (3) @(negedge clk_clk);
    chk("rst_s_en", {31'd0, s_bus_enable}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_grant", {31'd0, grant}, 0);
    chk("rst_rd0", {16'd0, m0_read_data}, 0);
    chk("rst_rd1", {16'd0, m1_read_data}, 0);
    chk("rst_err", {15'd0, err_flag, err_addr}, 0);
    reset_reset = 1'b0;
    @(negedge clk_clk);

    // Single read, ack in third GRANT cycle.
    xfer(0, 1'b1, 16'h0010, 2'b11, 16'h0000, 2, 16'h1234, lat, en_cyc);
    chk("read_latency", lat, 4);

    // Write leaves the read register alone.
    xfer(0, 1'b0, 16'h0020, 2'b01, 16'hA5A5, 0, 16'hFFFF, lat, en_cyc);
    chk("write_latency", lat, 2);

    // Timeouts: first address sticks, clear zeroes.
    xfer(1, 1'b1, 16'h00F0, 2'b11, 16'h0000, -1, 16'h0, lat, en_cyc);
    chk("tmo_en_cycles", en_cyc, TMO);
    chk("tmo_err_flag", {31'd0, err_flag}, 1);
    chk("tmo_err_addr", {16'd0, err_addr}, 32'h00F0);
    xfer(1, 1'b1, 16'h0100, 2'b11, 16'h0000, -1, 16'h0, lat, en_cyc);
    chk("tmo2_en_cycles", en_cyc, TMO);
    chk("tmo2_err_addr", {16'd0, err_addr}, 32'h00F0);
    err_clear = 1'b1;
    @(negedge clk_clk);
    err_clear = 1'b0;
    chk("clr_err_flag", {31'd0, err_flag}, 0);
    chk("clr_err_addr", {16'd0, err_addr}, 0);

    // Ack exactly in the last allowed GRANT cycle wins over timeout.
    xfer(0, 1'b1, 16'h0030, 2'b11, 16'h0000, TMO - 1, 16'h5555, lat, en_cyc);
    chk("edge_err_flag", {31'd0, err_flag}, 0);

    // Contention with instant acks, from reset.
    reset_reset = 1'b1;
    model[0] = 16'h0C0C; model[1] = 16'h0C0C;
    for (int i = 0; i < 4; i++) begin
      e.m = i % 2; e.d = 16'h0C0C;
      sb.push_back(e);
    end
    s_read_data = 16'h0C0C; auto_ack = 1'b1;
    set_req(0, 1'b1, 1'b1, 16'h0040, 2'b11, 16'h0);
    set_req(1, 1'b1, 1'b1, 16'h0050, 2'b11, 16'h0);
    @(negedge clk_clk);
    reset_reset = 1'b0;
    na = 0;
    for (int c = 0; c < 40 && na < 4; c++) begin
      @(negedge clk_clk);
      if (m0_acknowledge || m1_acknowledge) begin
        who[na] = m1_acknowledge ? 1 : 0;
        tk[na] = c;
        na++;
      end
    end
    set_req(0, 1'b0, 1'b0, 16'd0, 2'd0, 16'd0);
    set_req(1, 1'b0, 1'b0, 16'd0, 2'd0, 16'd0);
    auto_ack = 1'b0;
    chk("cont_acks", na, 4);
    if (na == 4) begin
      chk("cont_order", {who[0][7:0], who[1][7:0], who[2][7:0], who[3][7:0]},
          32'h00010001);
      chk("cont_m0_period", tk[2] - tk[0], 6);
      chk("cont_m1_period", tk[3] - tk[1], 6);
      chk("cont_gap", tk[1] - tk[0], 3);
    end
    repeat (2) @(negedge clk_clk);

    // Reset during GRANT: bus drops at once, no ack, pointer back to m0.
    set_req(1, 1'b1, 1'b1, 16'h0060, 2'b11, 16'h0);
    na = 0;
    for (int c = 0; c < 20 && !s_bus_enable; c++) @(negedge clk_clk);
    chk("rg_granted", {31'd0, s_bus_enable}, 1);
    #2 reset_reset = 1'b1;
    #1;
    chk("rg_s_en", {31'd0, s_bus_enable}, 0);
    chk("rg_busy", {31'd0, busy}, 0);
    chk("rg_acks", {30'd0, m1_acknowledge, m0_acknowledge}, 0);
    chk("rg_rd1", {16'd0, m1_read_data}, 0);
    chk("rg_grant", {31'd0, grant}, 0);
    model[0] = 16'h7777; model[1] = 16'h0;
    e.m = 0; e.d = 16'h7777;
    sb.push_back(e);
    set_req(0, 1'b1, 1'b1, 16'h0070, 2'b11, 16'h0);
    @(negedge clk_clk);
    reset_reset = 1'b0;
    for (int c = 0; c < 20 && !s_bus_enable; c++) @(negedge clk_clk);
    chk("rg_first_grant", {31'd0, grant}, 0);
    chk("rg_first_addr", {16'd0, s_address}, 32'h0070);
    s_ack_drv = 1'b1; s_read_data = 16'h7777;
    @(negedge clk_clk);
    s_ack_drv = 1'b0;
    set_req(0, 1'b0, 1'b0, 16'd0, 2'd0, 16'd0);
    set_req(1, 1'b0, 1'b0, 16'd0, 2'd0, 16'd0);
    repeat (3) @(negedge clk_clk);

    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1);
  end

endmodule
